window_sum_unpack: RTL and testbench
====================================

// Module: window_sum_unpack
// PURPOSE
//  Inverse of the TAPS-tap moving-sum filter. Takes the stream of windowed sums
//  S[n] = x[n] + x[n-1] + ... + x[n-TAPS+1] and reconstructs the raw samples
//  x[n] = S[n] - S[n-1] + x[n-TAPS], with all history zero at start.
//  Sits at the far end of the filtered-sample link; recovers the original data
//  for checking and for replay.
// PARAMETERS
//  TAPS  5   window length; must match the sending filter; >= 2
//  DW    8   raw sample width
//  SW    12  sum width; SW >= DW + clog2(TAPS)
//  CW    16  width of the emitted-sample counter
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous reset, active-low
//  clr        in   1   sync resync: zero history, prev-sum and output register
//  in_sum     in   SW  windowed sum S[n]
//  in_valid   in   1   in_sum valid
//  in_ready   out  1   block accepts in_sum this cycle
//  out_data   out  DW  reconstructed sample x[n]
//  out_valid  out  1   out_data valid
//  out_ready  in   1   downstream accepts out_data
//  locked     out  1   TAPS consecutive samples reconstructed without range error
//  err        out  1   sticky range error
//  count      out  CW  samples emitted (out_valid & out_ready), wraps mod 2^CW
// BEHAVIOUR
//  Reset (reset==0, async): out_valid=0, out_data=0, locked=0, err=0, count=0,
//   prev_sum=0, hist[0..TAPS-1]=0, fill=0. in_ready=1 once reset is released.
//  Handshake: in_ready = !clr && (!out_valid || out_ready). Accept = in_valid & in_ready.
//   On accept, out_data/out_valid load on the next edge. Latency 1 cycle.
//   Full throughput with out_ready held high. out_data stays stable while
//   out_valid & !out_ready.
//  Arithmetic: d = in_sum - prev_sum + hist[TAPS-1], evaluated signed in SW+2 bits.
//   If 0 <= d <= 2^DW-1: out_data = d[DW-1:0].
//   Else: clamp (d<0 -> 0; d>max -> 2^DW-1), set err, fill=0.
//  On accept: prev_sum <= in_sum; hist shifts (hist[0] <= clamped x; hist[k] <= hist[k-1]).
//   History stores the clamped value.
//  Fill: on each error-free accept, fill increments, saturating at TAPS.
//   locked = (fill==TAPS). An error drops locked on the same edge.
//  count increments on each out_valid & out_ready edge. Wraps 2^CW-1 -> 0.
//  clr (sync) takes priority over everything except reset:
//   - zeroes prev_sum, hist, fill, out_valid, err, locked;
//   - count unaffected;
//   - in_ready is low during clr, so no sample is taken in that cycle;
//   - a held output is dropped (no count increment that cycle).
//  err is sticky; only clr or reset clears it.
//  Reset mid-stream: all state clears immediately; the next accepted sum is treated as S[0].
//  Simultaneous out pop + in accept: both occur; out_valid stays 1 with the new data.
// TESTING
//  1 Ramp: x=1,2,3,4,5,6 -> sums 1,3,6,10,15,20 in; out 1,2,3,4,5,6;
//    locked rises with the 5th output; count=6.
//  2 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0;
//    out_data held at first value; no loss or duplication after release.
//  3 Max: x=255 x6 -> sums 255,510,765,1020,1275,1275; all outputs 255; err=0.
//  4 Corrupt: after sums 10,30, inject sum 5 -> d=-25 -> out 0, err=1, locked=0;
//    err stays 1 until clr.
//  5 clr asserted with in_valid=1 and out_valid=1 -> no accept, out_valid=0;
//    next sum 7 -> out 7.
//  6 count wrap: CW=4, 17 transfers -> count=1. Async reset mid-burst ->
//    out_valid=0 immediately; restart ramp reproduces test 1.

Source files
------------

// File: rtl/window_sum_unpack.sv
// Inverse of a TAPS-tap moving-sum filter: rebuilds raw samples from windowed sums
// as x[n] = S[n] - S[n-1] + x[n-TAPS], with range clamping and lock/error tracking.
module window_sum_unpack #(
    parameter int unsigned TAPS = 5,
    parameter int unsigned DW   = 8,
    parameter int unsigned SW   = 12,
    parameter int unsigned CW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [SW-1:0] in_sum,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] count
);

    localparam int unsigned FW = $clog2(TAPS + 1);
    localparam int unsigned XW = SW + 2;
    localparam logic [FW-1:0] FILL_MAX = FW'(TAPS);
    localparam logic signed [XW-1:0] DMAX = XW'((1 << DW) - 1);

    logic [SW-1:0]        prev_sum;
    logic [DW-1:0]        hist [TAPS];
    logic [FW-1:0]        fill;
    logic signed [XW-1:0] d;
    logic [DW-1:0]        x_clamp;
    logic                 range_err;
    logic                 accept;

    assign in_ready = !clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign locked   = (fill == FILL_MAX);

    // Two guard bits keep the signed difference exact for any pair of sums.
    always_comb begin
        d = $signed({2'b00, in_sum}) - $signed({2'b00, prev_sum})
            + $signed(XW'(hist[TAPS-1]));
        x_clamp   = d[DW-1:0];
        range_err = 1'b0;
        if (d < 0) begin
            x_clamp   = '0;
            range_err = 1'b1;
        end else if (d > DMAX) begin
            x_clamp   = '1;
            range_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sum  <= '0;
            fill      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            for (int unsigned k = 0; k < TAPS; k++) hist[k] <= '0;
        end else if (clr) begin
            // Resync drops any held output without counting it; count survives.
            prev_sum  <= '0;
            fill      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) hist[k] <= '0;
        end else begin
            if (out_valid && out_ready) count <= count + 1'b1;
            if (accept) begin
                out_data  <= x_clamp;
                out_valid <= 1'b1;
                prev_sum  <= in_sum;
                hist[0]   <= x_clamp;
                for (int unsigned k = 1; k < TAPS; k++) hist[k] <= hist[k-1];
                if (range_err) begin
                    err  <= 1'b1;
                    fill <= '0;
                end else if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_sum_unpack.sv
// Self-checking bench for window_sum_unpack: directed scenarios plus a randomized
// stream compared against raw samples that were moving-summed inside the bench.
module tb_window_sum_unpack;

    localparam int TAPS = 5;
    localparam int DW   = 8;
    localparam int SW   = 12;
    localparam int CW   = 4;
    localparam int NR   = 60;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic [SW-1:0] in_sum = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    window_sum_unpack #(.TAPS(TAPS), .DW(DW), .SW(SW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input logic r);
        in_valid  = v;
        in_sum    = SW'(s);
        out_ready = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0);
        clr   = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Moving sum of the raw samples with zero history before index 0.
    function automatic int wsum(input int xs[NR], input int n);
        int s = 0;
        for (int k = 0; k < TAPS; k++) if (n - k >= 0) s += xs[n-k];
        return s;
    endfunction

    task automatic run_ramp(input string tag);
        int sums[6] = '{1, 3, 6, 10, 15, 20};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, sums[i], 1'b1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
                errors++;
                $display("FAIL %s_data[%0d] got v=%0b d=%0d exp v=1 d=%0d",
                         tag, i, out_valid, out_data, i + 1);
            end
            checks++;
            if (locked !== (i >= TAPS - 1)) begin
                errors++;
                $display("FAIL %s_locked[%0d] got %0b exp %0b", tag, i, locked, i >= TAPS - 1);
            end
        end
        drive(1'b0, 0, 1'b1);
        step();
        checks++;
        if (count !== 4'd6 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_count got %0d v=%0b exp 6 v=0", tag, count, out_valid);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 77, 1'b1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || locked !== 1'b0 || err !== 1'b0
            || count !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b d=%0d l=%0b e=%0b c=%0d exp all 0",
                     out_valid, out_data, locked, err, count);
        end
        drive(1'b0, 0, 1'b0);
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        run_ramp("ramp");
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1, 1'b1);
        step();
        drive(1'b1, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b d=%0d exp v=1 d=1", i, out_valid, out_data);
            end
        end
        drive(1'b1, 3, 1'b1);
        step();
        checks++;
        if (out_data !== 8'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%0b d=%0d exp v=1 d=2", out_valid, out_data);
        end
        drive(1'b1, 6, 1'b1);
        step();
        checks++;
        if (out_data !== 8'd3) begin
            errors++;
            $display("FAIL bp_next got %0d exp 3", out_data);
        end
        drive(1'b0, 0, 1'b1);
        step();
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL bp_count got %0d exp 3", count);
        end
    endtask

    task automatic test_max();
        int sums[6] = '{255, 510, 765, 1020, 1275, 1275};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, sums[i], 1'b1);
            step();
            checks++;
            if (out_data !== 8'd255 || err !== 1'b0) begin
                errors++;
                $display("FAIL max[%0d] got d=%0d e=%0b exp d=255 e=0", i, out_data, err);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL max_locked got %0b exp 1", locked);
        end
    endtask

    task automatic test_corrupt();
        do_reset();
        drive(1'b1, 10, 1'b1);
        step();
        drive(1'b1, 30, 1'b1);
        step();
        checks++;
        if (out_data !== 8'd20) begin
            errors++;
            $display("FAIL corrupt_pre got %0d exp 20", out_data);
        end
        drive(1'b1, 5, 1'b1);
        step();
        checks++;
        if (out_data !== 8'd0 || err !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_neg got d=%0d e=%0b l=%0b exp d=0 e=1 l=0",
                     out_data, err, locked);
        end
        drive(1'b1, 5, 1'b1);
        step();
        drive(1'b0, 0, 1'b1);
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL corrupt_sticky got %0b exp 1", err);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL corrupt_clr got %0b exp 0", err);
        end
        drive(1'b1, 300, 1'b1);
        step();
        checks++;
        if (out_data !== 8'd255 || err !== 1'b1) begin
            errors++;
            $display("FAIL corrupt_high got d=%0d e=%0b exp d=255 e=1", out_data, err);
        end
    endtask

    task automatic test_clr();
        do_reset();
        drive(1'b1, 4, 1'b1);
        step();
        drive(1'b1, 9, 1'b1);
        clr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_ready got %0b exp 0", in_ready);
        end
        step();
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL clr_drop got v=%0b c=%0d exp v=0 c=0", out_valid, count);
        end
        drive(1'b1, 7, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd7) begin
            errors++;
            $display("FAIL clr_resume got v=%0b d=%0d exp v=1 d=7", out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        int xs[NR];
        do_reset();
        for (int i = 0; i < NR; i++) xs[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, wsum(xs, i), 1'b1);
            step();
            checks++;
            if (out_data !== 8'(xs[i])) begin
                errors++;
                $display("FAIL wrap_data[%0d] got %0d exp %0d", i, out_data, xs[i]);
            end
        end
        drive(1'b0, 0, 1'b1);
        step();
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 1", count);
        end
        drive(1'b1, 5, 1'b1);
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset got v=%0b c=%0d l=%0b exp 0 0 0", out_valid, count, locked);
        end
        drive(1'b0, 0, 1'b0);
        step();
        reset = 1'b1;
        run_ramp("reramp");
    endtask

    task automatic test_random();
        int xs[NR];
        int idx = 0, nacc = 0, mcount = 0, mdata = 0, cyc = 0;
        logic mov = 1'b0, v, r;
        do_reset();
        for (int i = 0; i < NR; i++) xs[i] = int'($urandom_range(0, 255));
        while (idx < NR || mov) begin
            if (cyc++ > 1000) begin
                errors++;
                $display("FAIL rand_timeout got idx=%0d exp %0d", idx, NR);
                break;
            end
            v = (idx < NR) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, (idx < NR) ? wsum(xs, idx) : 0, r);
            #1;
            checks++;
            if (out_valid !== mov || (mov && out_data !== 8'(mdata))) begin
                errors++;
                $display("FAIL rand_out got v=%0b d=%0d exp v=%0b d=%0d",
                         out_valid, out_data, mov, mdata);
            end
            checks++;
            if (in_ready !== (!mov || r)) begin
                errors++;
                $display("FAIL rand_in_ready got %0b exp %0b", in_ready, !mov || r);
            end
            if (mov && r) mcount++;
            if (v && (!mov || r)) begin
                mdata = xs[idx];
                mov   = 1'b1;
                idx++;
                nacc++;
            end else if (r) begin
                mov = 1'b0;
            end
            step();
            checks++;
            if (count !== 4'(mcount) || locked !== (nacc >= TAPS) || err !== 1'b0) begin
                errors++;
                $display("FAIL rand_status got c=%0d l=%0b e=%0b exp c=%0d l=%0b e=0",
                         count, locked, err, mcount % 16, nacc >= TAPS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_max();
        test_corrupt();
        test_clr();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
